int_result_arb: RTL and testbench
=================================

# int_result_arb

Arbitrates the three result channels of the intersection unit into the single pixel-buffer write port: shader hits, shortstack misses and shortstack early-miss (EM) results. Each channel is granted round-robin. Granted results are colour-mapped and queued in a small output FIFO, which drains into the pixel buffer under its `full` backpressure. The block sits between `int_unit` and the pixel buffer. It replaces ad-hoc fixed-priority muxing with fair arbitration and registered backpressure.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: output queue entries (power of 2, ≥2).
- `MISS_COLOR`, default 24'h11_22_33: colour for shortstack and EM miss results.
- `HIT_COLOR_MATCH`, default 24'h44_55_66: colour for a hit whose triID equals `HIT_TRIID`.
- `HIT_COLOR_OTHER`, default 24'h77_88_99: colour for any other hit.
- `HIT_TRIID`, default 2: triID selecting `HIT_COLOR_MATCH`.

Ports:
- `clk`, in, 1: single clock. Everything is posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `int_to_shader_valid`, in, 1: hit result valid (channel 0).
- `int_to_shader_rayID`, in, rayID_t: hit ray ID.
- `int_to_shader_intersection`, in, intersection_t: hit record. Only `.triID` is used.
- `int_to_shader_stall`, out, 1: backpressure to channel 0.
- `int_to_shortstack_valid`, in, 1: miss result valid (channel 1).
- `int_to_shortstack_rayID`, in, rayID_t: miss ray ID.
- `int_to_shortstack_stall`, out, 1: backpressure to channel 1.
- `int_to_shortstack_EM_valid`, in, 1: EM miss valid (channel 2).
- `int_to_shortstack_EM_rayID`, in, rayID_t: EM ray ID.
- `int_to_shortstack_EM_stall`, out, 1: backpressure to channel 2.
- `we`, out, 1: pixel buffer write strobe.
- `full`, in, 1: pixel buffer cannot accept a write this cycle.
- `pixel_entry_out`, out, pixel_buffer_entry_t: `{color, rayID}` written when `we`=1.

## Operation
- Channel protocol: a transfer occurs in a cycle where valid=1 and stall=0. The producer holds valid and data stable while stalled.
- `space` = (registered `count` < `FIFO_DEPTH`). It is computed from the registered count only, with no same-cycle pop bypass.
- Round-robin pointer `rr_ptr` takes values 0..2. Search order is `rr_ptr`, `rr_ptr`+1, `rr_ptr`+2 (mod 3). The first valid channel in that order is the candidate.
- Grant: if a candidate exists and `space`=1, the candidate's stall=0 and the transfer happens. Every other stall=1.
- If `space`=0, all stalls are 1. Stall for a non-valid channel is a don't-care but must be 1 in RTL.
- After a grant to channel g, `rr_ptr` ← (g+1) mod 3. With no grant, `rr_ptr` holds.
- Colour map:
  - Channel 0: `HIT_COLOR_MATCH` if triID == `HIT_TRIID`, else `HIT_COLOR_OTHER`.
  - Channels 1 and 2: `MISS_COLOR`.
- The pushed entry is `{color, rayID}`.
- Output FIFO:
  - `we` = (`count` ≠ 0) & ~`full`.
  - `pixel_entry_out` = head entry when `count` ≠ 0, else all-zero.
  - Pop happens when `we`=1.
- `count` update: push only → +1; pop only → −1; push and pop in the same cycle → unchanged (allowed for any count < `FIFO_DEPTH`).
- Read and write pointers wrap modulo `FIFO_DEPTH`. Order is strictly FIFO.
- Reset, effective on the next edge: `count`=0, pointers=0, `rr_ptr`=0. Until the first post-reset edge, and while `rst`=1, all stalls are 1, `we`=0 and `pixel_entry_out`=0.
- Reset mid-operation discards all queued entries. No write occurs in the cycle `rst` is sampled high.

## Timing
- Latency: an entry granted at edge N is at the head from cycle N+1. `we`=1 in cycle N+1 if it is the oldest entry and `full`=0.
- Throughput is 1 grant and 1 write per cycle when `full`=0.
- `full`=1 blocks the pop only. Grants continue until `count` reaches `FIFO_DEPTH`.
- When `count`==`FIFO_DEPTH` and a pop occurs, no grant happens that cycle (registered `space`). Grants resume the next cycle.
- Fairness: with all three channels continuously valid and `full`=0, the grant sequence from reset is 0,1,2,0,1,2,…
- Stall is combinational from valid, `rr_ptr` and `count`. It has no combinational path from `full`.

## Test plan
- Single hit: after reset, present channel 0 valid with rayID=5 and triID=2 for one cycle, `full`=0. Required: the transfer happens that cycle, and the next cycle has `we`=1 and entry `{24'h445566, 5}`.
- Colour map: hit with triID=7, then a channel 1 miss (rayID=3), then a channel 2 EM miss (rayID=4). Required: writes in order `{778899,…}`, `{112233,3}`, `{112233,4}`.
- Round-robin: hold all three channels valid for 6 cycles with `full`=0. Required: grants 0,1,2,0,1,2. Each non-granted channel's stall=1 in every cycle it is not granted.
- Backpressure: hold `full`=1 with channel 1 continuously valid. Required: exactly 4 transfers, then stall=1, `we`=0. Release `full`: 4 writes in order, grants resume one cycle after the first pop.
- Simultaneous push/pop at `count`=2: `count` stays 2 and ordering is preserved. At `count`=4 with a pop, there is no grant that cycle.
- Reset mid-stream: assert `rst` with 3 entries queued. Required: `we`=0 and all stalls=1 on the following cycle, then `count`=0, and the next grant goes to channel 0 if valid.

Source files
------------

// File: rtl/int_result_arb.sv
// Round-robin arbiter that merges three intersection result channels into the pixel-buffer write port.
// Latency: a result granted at edge N sits at the queue head, and is writable, from cycle N+1.
// Backpressure: `full` only blocks the pop; a full queue stalls every channel, with no same-cycle pop bypass.

// Small synchronous FIFO. The caller must never push when count_o == DEPTH.
module int_result_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state pointers and occupancy; DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset; discards all queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !rst) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
endmodule

module int_result_arb #(
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [23:0] MISS_COLOR      = 24'h11_22_33,
    parameter logic [23:0] HIT_COLOR_MATCH = 24'h44_55_66,
    parameter logic [23:0] HIT_COLOR_OTHER = 24'h77_88_99,
    parameter int          HIT_TRIID       = 2,
    parameter int          RAYID_W         = 8,
    parameter int          TRIID_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    // channel 0: shader hits (only the triID of the intersection record is carried)
    input  logic                   int_to_shader_valid,
    input  logic [RAYID_W-1:0]     int_to_shader_rayID,
    input  logic [TRIID_W-1:0]     int_to_shader_intersection,
    output logic                   int_to_shader_stall,
    // channel 1: shortstack misses
    input  logic                   int_to_shortstack_valid,
    input  logic [RAYID_W-1:0]     int_to_shortstack_rayID,
    output logic                   int_to_shortstack_stall,
    // channel 2: shortstack early-miss results
    input  logic                   int_to_shortstack_EM_valid,
    input  logic [RAYID_W-1:0]     int_to_shortstack_EM_rayID,
    output logic                   int_to_shortstack_EM_stall,
    // pixel buffer write port; entry is {color, rayID}
    output logic                   we,
    input  logic                   full,
    output logic [24+RAYID_W-1:0]  pixel_entry_out
);
    localparam int ENTRY_W = 24 + RAYID_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TRIID_W-1:0] MATCH_ID = TRIID_W'(HIT_TRIID);

    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]         chan_vld;
    logic [1:0]         ord0, ord1, ord2;
    logic [1:0]         cand;
    logic               cand_vld;
    logic               space;
    logic               grant;
    logic               pop;
    logic [23:0]        push_color;
    logic [RAYID_W-1:0] push_ray;
    logic [ENTRY_W-1:0] head_dat;
    logic [CNT_W-1:0]   count;

    // Bit 3 is a constant pad so the 2-bit search index never falls outside the vector.
    assign chan_vld = {1'b0, int_to_shortstack_EM_valid, int_to_shortstack_valid, int_to_shader_valid};

    // Space comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign space = (count < DEPTH_C);

    // Round-robin search: the first valid channel starting at rr_ptr is the candidate.
    always_comb begin
        ord0     = 2'd0;
        ord1     = 2'd1;
        ord2     = 2'd2;
        cand     = 2'd0;
        cand_vld = 1'b0;
        case (rr_ptr_q)
            2'd1: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd2: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase
        if (chan_vld[ord0]) begin
            cand     = ord0;
            cand_vld = 1'b1;
        end else if (chan_vld[ord1]) begin
            cand     = ord1;
            cand_vld = 1'b1;
        end else if (chan_vld[ord2]) begin
            cand     = ord2;
            cand_vld = 1'b1;
        end
    end

    // Reset forces every stall high, which also keeps the not-yet-reset pointer from granting.
    assign grant = cand_vld && space && !rst;

    assign int_to_shader_stall        = !(grant && (cand == 2'd0));
    assign int_to_shortstack_stall    = !(grant && (cand == 2'd1));
    assign int_to_shortstack_EM_stall = !(grant && (cand == 2'd2));

    // Colour-map the granted result and select its ray ID.
    always_comb begin
        push_color = MISS_COLOR;
        push_ray   = int_to_shortstack_EM_rayID;
        case (cand)
            2'd0: begin
                push_ray   = int_to_shader_rayID;
                push_color = (int_to_shader_intersection == MATCH_ID) ? HIT_COLOR_MATCH
                                                                      : HIT_COLOR_OTHER;
            end
            2'd1: begin
                push_ray   = int_to_shortstack_rayID;
                push_color = MISS_COLOR;
            end
            default: begin
                push_ray   = int_to_shortstack_EM_rayID;
                push_color = MISS_COLOR;
            end
        endcase
    end

    // The pointer moves just past the granted channel; it holds when nothing is granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    int_result_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (grant),
        .push_dat_i ({push_color, push_ray}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    // The write strobe is the pop; reset suppresses it so nothing drains in the reset cycle.
    assign pop             = (count != '0) && !full && !rst;
    assign we              = pop;
    assign pixel_entry_out = ((count != '0) && !rst) ? head_dat : '0;
endmodule

// File: tb/tb_int_result_arb.sv
module tb_int_result_arb;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sh_v, ss_v, em_v;
    logic [7:0]  sh_ray, sh_tid, ss_ray, em_ray;
    logic        sh_stall, ss_stall, em_stall;
    logic        we, full;
    logic [31:0] entry;

    int          checks = 0;
    int          errors = 0;
    int          m_rr   = 0;
    logic [31:0] sbq[$];
    int          grant_log[$];
    logic [31:0] write_log[$];

    always #5 clk = ~clk;

    int_result_arb dut (
        .clk                        (clk),
        .rst                        (rst),
        .int_to_shader_valid        (sh_v),
        .int_to_shader_rayID        (sh_ray),
        .int_to_shader_intersection (sh_tid),
        .int_to_shader_stall        (sh_stall),
        .int_to_shortstack_valid    (ss_v),
        .int_to_shortstack_rayID    (ss_ray),
        .int_to_shortstack_stall    (ss_stall),
        .int_to_shortstack_EM_valid (em_v),
        .int_to_shortstack_EM_rayID (em_ray),
        .int_to_shortstack_EM_stall (em_stall),
        .we                         (we),
        .full                       (full),
        .pixel_entry_out            (entry)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_entry(input int ch);
        logic [31:0] e;
        if (ch == 0) e = {((sh_tid == 8'd2) ? 24'h445566 : 24'h778899), sh_ray};
        else if (ch == 1) e = {24'h112233, ss_ray};
        else e = {24'h112233, em_ray};
        return e;
    endfunction

    // One clock: predict and check outputs at the negedge, then advance the model at the posedge.
    task automatic cycle();
        logic [2:0]  v;
        logic [2:0]  st;
        logic [31:0] exp_e;
        logic [31:0] new_e;
        logic        exp_we;
        int          g;
        int          c;
        @(negedge clk);
        v  = {em_v, ss_v, sh_v};
        st = {em_stall, ss_stall, sh_stall};
        g  = -1;
        if (!rst && sbq.size() < DEPTH) begin
            for (int k = 0; k < 3; k++) begin
                c = (m_rr + k) % 3;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_we = !rst && (sbq.size() != 0) && !full;
        exp_e  = (!rst && sbq.size() != 0) ? sbq[0] : 32'h0;
        check("stall_ch0", {63'h0, st[0]}, {63'h0, (g != 0)});
        check("stall_ch1", {63'h0, st[1]}, {63'h0, (g != 1)});
        check("stall_ch2", {63'h0, st[2]}, {63'h0, (g != 2)});
        check("we", {63'h0, we}, {63'h0, exp_we});
        check("entry", {32'h0, entry}, {32'h0, exp_e});
        for (int i = 0; i < 3; i++) begin
            if (v[i] && !st[i]) grant_log.push_back(i);
        end
        if (we === 1'b1) write_log.push_back(entry);
        new_e = (g >= 0) ? exp_entry(g) : 32'h0;
        @(posedge clk);
        if (rst) begin
            sbq.delete();
            m_rr = 0;
        end else begin
            if (exp_we) void'(sbq.pop_front());
            if (g >= 0) begin
                sbq.push_back(new_e);
                m_rr = (g + 1) % 3;
            end
        end
        #1;
    endtask

    task automatic ss_step();
        int n;
        n = grant_log.size();
        cycle();
        if (grant_log.size() != n) ss_ray = ss_ray + 8'd1;
    endtask

    task automatic idle(input int n);
        sh_v = 1'b0; ss_v = 1'b0; em_v = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int n;
        rst = 1'b1; full = 1'b0;
        sh_v = 1'b0; ss_v = 1'b0; em_v = 1'b0;
        sh_ray = 8'd0; sh_tid = 8'd0; ss_ray = 8'd0; em_ray = 8'd0;
        cycle();
        cycle();
        rst = 1'b0;
        idle(2);

        // single hit with matching triID
        write_log.delete();
        sh_v = 1'b1; sh_ray = 8'd5; sh_tid = 8'd2;
        cycle();
        idle(3);
        check("hit_writes", write_log.size(), 1);
        if (write_log.size() > 0) check("hit_entry", write_log[0], 32'h44556605);

        // colour map across all three channels
        write_log.delete();
        sh_v = 1'b1; sh_ray = 8'd9; sh_tid = 8'd7;
        cycle();
        sh_v = 1'b0; ss_v = 1'b1; ss_ray = 8'd3;
        cycle();
        ss_v = 1'b0; em_v = 1'b1; em_ray = 8'd4;
        cycle();
        idle(4);
        check("cmap_writes", write_log.size(), 3);
        if (write_log.size() == 3) begin
            check("cmap_hit_other", write_log[0], 32'h77889909);
            check("cmap_miss", write_log[1], 32'h11223303);
            check("cmap_em", write_log[2], 32'h11223304);
        end

        // round robin with all channels valid
        grant_log.delete();
        sh_v = 1'b1; ss_v = 1'b1; em_v = 1'b1;
        sh_ray = 8'd1; sh_tid = 8'd0; ss_ray = 8'd2; em_ray = 8'd3;
        for (int i = 0; i < 6; i++) cycle();
        idle(4);
        check("rr_count", grant_log.size(), 6);
        if (grant_log.size() == 6) begin
            for (int i = 0; i < 6; i++) check("rr_seq", grant_log[i], i % 3);
        end

        // backpressure: queue fills to depth, then drains in order
        grant_log.delete(); write_log.delete();
        full = 1'b1; ss_v = 1'b1; ss_ray = 8'd7;
        for (int i = 0; i < 8; i++) ss_step();
        check("bp_transfers", grant_log.size(), 4);
        check("bp_no_write", write_log.size(), 0);
        full = 1'b0;
        n = grant_log.size();
        ss_step();
        check("bp_no_grant_on_pop", grant_log.size() - n, 0);
        ss_step();
        check("bp_grant_resumes", grant_log.size() - n, 1);
        idle(8);
        check("bp_write_count", write_log.size(), 5);
        if (write_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("bp_order", write_log[i], {24'h112233, 8'(7 + i)});
        end

        // simultaneous push and pop at two entries
        grant_log.delete(); write_log.delete();
        full = 1'b1; ss_v = 1'b1; ss_ray = 8'h20;
        ss_step();
        ss_step();
        full = 1'b0;
        n = grant_log.size();
        for (int i = 0; i < 4; i++) ss_step();
        check("pp_grants", grant_log.size() - n, 4);
        check("pp_writes", write_log.size(), 4);
        idle(4);
        check("pp_total_writes", write_log.size(), 6);
        if (write_log.size() == 6) begin
            for (int i = 0; i < 6; i++) check("pp_order", write_log[i], {24'h112233, 8'(8'h20 + i)});
        end

        // reset with three entries queued
        full = 1'b1; em_v = 1'b1; em_ray = 8'h30;
        for (int i = 0; i < 3; i++) cycle();
        check("rst_prefill", sbq.size(), 3);
        sh_v = 1'b1; ss_v = 1'b1; sh_ray = 8'h31; ss_ray = 8'h32; full = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        grant_log.delete(); write_log.delete();
        cycle();
        check("rst_no_stale_write", write_log.size(), 0);
        check("rst_first_grant_n", grant_log.size(), 1);
        if (grant_log.size() > 0) check("rst_first_grant", grant_log[0], 0);
        idle(5);
        check("rst_write_after", write_log.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
